// File: rtl/l1_mesi_cache_ctrl.sv
// L1 MESI tag/state controller: WAYS-way set-associative tags, per-line MESI and true-LRU, no data array.
// Response 2/3/4/SETS+2 cycles after accept (hit or snoop / clean miss / dirty op / CLR); req_ready only in IDLE.
module l1_mesi_cache_ctrl #(
   parameter int ADDR_W      = 32,
   parameter int OFFSET_BITS = 6,
   parameter int INDEX_BITS  = 4,
   parameter int WAYS        = 8,
   parameter int CNT_W       = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [3:0]              req_cmd,
   input  logic [ADDR_W-1:0]       req_addr,
   output logic                    rsp_valid,
   output logic                    rsp_hit,
   output logic [$clog2(WAYS)-1:0] rsp_way,
   output logic [1:0]              rsp_mesi,
   output logic                    l2_op_valid,
   output logic [1:0]              l2_op,
   output logic [ADDR_W-1:0]       l2_addr,
   output logic [CNT_W-1:0]        stat_reads,
   output logic [CNT_W-1:0]        stat_writes,
   output logic [CNT_W-1:0]        stat_hits,
   output logic [CNT_W-1:0]        stat_misses
);
   localparam int SETS     = 2 ** INDEX_BITS;
   localparam int LRU_W    = $clog2(WAYS);
   localparam int TAG_BITS = ADDR_W - INDEX_BITS - OFFSET_BITS;

   localparam logic [3:0] CMD_READ = 4'd0, CMD_WRITE = 4'd1, CMD_IFETCH = 4'd2;
   localparam logic [3:0] CMD_INVAL = 4'd3, CMD_DATA_RQ = 4'd4, CMD_CLR = 4'd8;
   localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_E = 2'd2, ST_M = 2'd3;
   localparam logic [1:0] OP_READ = 2'd0, OP_RFO = 2'd1, OP_WB = 2'd2;

   typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, FILL, CLEAR, RESP} state_t;

   state_t                state_q, state_d;
   logic [3:0]            cmd_q, cmd_d;
   logic [TAG_BITS-1:0]   rtag_q, rtag_d;
   logic [INDEX_BITS-1:0] set_q, set_d;
   logic [INDEX_BITS-1:0] clr_q, clr_d;
   logic [LRU_W-1:0]      way_q, way_d;
   logic                  hit_q, hit_d;
   logic [TAG_BITS-1:0]   tag_q [SETS][WAYS], tag_d [SETS][WAYS];
   logic [1:0]            mesi_q [SETS][WAYS], mesi_d [SETS][WAYS];
   logic [LRU_W-1:0]      lru_q [SETS][WAYS], lru_d [SETS][WAYS];
   logic [CNT_W-1:0]      reads_q, reads_d, writes_q, writes_d, hits_q, hits_d, misses_q, misses_d;

   logic             lk_hit, is_cpu, is_wr, touch_en, show_way;
   logic [LRU_W-1:0] lk_way, vict_way, touch_way;
   logic             unused_offset;

   assign unused_offset = ^req_addr[OFFSET_BITS-1:0];
   assign is_cpu = (cmd_q == CMD_READ) || (cmd_q == CMD_WRITE) || (cmd_q == CMD_IFETCH);
   assign is_wr  = (cmd_q == CMD_WRITE);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Victim: oldest way by default, overridden by the lowest-numbered invalid way.
   always_comb begin
      lk_hit   = 1'b0;
      lk_way   = '0;
      vict_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (mesi_q[set_q][w] != ST_I && tag_q[set_q][w] == rtag_q) begin
            lk_hit = 1'b1;
            lk_way = LRU_W'(w);
         end
      end
      for (int w = WAYS-1; w >= 0; w--)
         if (lru_q[set_q][w] == LRU_W'(WAYS-1)) vict_way = LRU_W'(w);
      for (int w = WAYS-1; w >= 0; w--)
         if (mesi_q[set_q][w] == ST_I) vict_way = LRU_W'(w);
   end

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      rtag_d      = rtag_q;
      set_d       = set_q;
      clr_d       = clr_q;
      way_d       = way_q;
      hit_d       = hit_q;
      tag_d       = tag_q;
      mesi_d      = mesi_q;
      lru_d       = lru_q;
      reads_d     = reads_q;
      writes_d    = writes_q;
      hits_d      = hits_q;
      misses_d    = misses_q;
      touch_en    = 1'b0;
      touch_way   = '0;
      l2_op_valid = 1'b0;
      l2_op       = OP_READ;
      l2_addr     = '0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               state_d = LOOKUP;
               cmd_d   = req_cmd;
               rtag_d  = req_addr[ADDR_W-1 -: TAG_BITS];
               set_d   = req_addr[OFFSET_BITS +: INDEX_BITS];
            end
         end
         LOOKUP: begin
            state_d = RESP;
            hit_d   = lk_hit && (is_cpu || cmd_q == CMD_INVAL || cmd_q == CMD_DATA_RQ);
            way_d   = lk_hit ? lk_way : vict_way;
            if (is_cpu) begin
               if (is_wr) writes_d = sat_inc(writes_q);
               else       reads_d  = sat_inc(reads_q);
               if (lk_hit) hits_d = sat_inc(hits_q);
               else        misses_d = sat_inc(misses_q);
               if (lk_hit) begin
                  touch_en  = 1'b1;
                  touch_way = lk_way;
                  // A shared line needs ownership from L2 before it may be modified.
                  if (is_wr && mesi_q[set_q][lk_way] == ST_S) state_d = FILL;
                  else if (is_wr) mesi_d[set_q][lk_way] = ST_M;
               end else begin
                  state_d = (mesi_q[set_q][vict_way] == ST_M) ? EVICT : FILL;
               end
            end else if (cmd_q == CMD_INVAL) begin
               if (lk_hit) mesi_d[set_q][lk_way] = ST_I;
            end else if (cmd_q == CMD_DATA_RQ) begin
               if (lk_hit && mesi_q[set_q][lk_way] == ST_M) state_d = EVICT;
               else if (lk_hit && mesi_q[set_q][lk_way] == ST_E) mesi_d[set_q][lk_way] = ST_S;
            end else if (cmd_q == CMD_CLR) begin
               reads_d  = '0;
               writes_d = '0;
               hits_d   = '0;
               misses_d = '0;
               clr_d    = '0;
               state_d  = CLEAR;
            end
         end
         EVICT: begin
            l2_op_valid = 1'b1;
            l2_op       = OP_WB;
            l2_addr     = {tag_q[set_q][way_q], set_q, {OFFSET_BITS{1'b0}}};
            state_d     = FILL;
         end
         FILL: begin
            state_d = RESP;
            // Snoop downgrade completes here so an M snoop spends one cycle after its write-back.
            if (cmd_q == CMD_DATA_RQ) begin
               mesi_d[set_q][way_q] = ST_S;
            end else begin
               l2_op_valid          = 1'b1;
               l2_op                = is_wr ? OP_RFO : OP_READ;
               l2_addr              = {rtag_q, set_q, {OFFSET_BITS{1'b0}}};
               tag_d[set_q][way_q]  = rtag_q;
               mesi_d[set_q][way_q] = is_wr ? ST_M : ST_E;
               if (!hit_q) begin
                  touch_en  = 1'b1;
                  touch_way = way_q;
               end
            end
         end
         CLEAR: begin
            for (int w = 0; w < WAYS; w++) begin
               mesi_d[clr_q][w] = ST_I;
               lru_d[clr_q][w]  = LRU_W'(w);
            end
            if (clr_q == INDEX_BITS'(SETS-1)) state_d = RESP;
            else clr_d = clr_q + 1'b1;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (touch_en) begin
         for (int w = 0; w < WAYS; w++)
            if (lru_q[set_q][w] < lru_q[set_q][touch_way]) lru_d[set_q][w] = lru_q[set_q][w] + 1'b1;
         lru_d[set_q][touch_way] = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cmd_q    <= '0;
         rtag_q   <= '0;
         set_q    <= '0;
         clr_q    <= '0;
         way_q    <= '0;
         hit_q    <= 1'b0;
         reads_q  <= '0;
         writes_q <= '0;
         hits_q   <= '0;
         misses_q <= '0;
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               tag_q[s][w]  <= '0;
               mesi_q[s][w] <= ST_I;
               lru_q[s][w]  <= LRU_W'(w);
            end
         end
      end else begin
         state_q  <= state_d;
         cmd_q    <= cmd_d;
         rtag_q   <= rtag_d;
         set_q    <= set_d;
         clr_q    <= clr_d;
         way_q    <= way_d;
         hit_q    <= hit_d;
         reads_q  <= reads_d;
         writes_q <= writes_d;
         hits_q   <= hits_d;
         misses_q <= misses_d;
         tag_q    <= tag_d;
         mesi_q   <= mesi_d;
         lru_q    <= lru_d;
      end
   end

   assign req_ready   = (state_q == IDLE);
   assign rsp_valid   = (state_q == RESP);
   assign show_way    = rsp_valid && (is_cpu || hit_q);
   assign rsp_hit     = rsp_valid && hit_q;
   assign rsp_way     = show_way ? way_q : '0;
   assign rsp_mesi    = show_way ? mesi_q[set_q][way_q] : ST_I;
   assign stat_reads  = reads_q;
   assign stat_writes = writes_q;
   assign stat_hits   = hits_q;
   assign stat_misses = misses_q;
endmodule
